// File: rtl/dp_mpp_ctrl.sv
// Rotation controller for the dp multi-ping-pong buffer set: assigns fill/NTT/consume
// roles to NUM_BUF banks, gates rotation on sticky per-core dones and issues start pulses.
module dp_mpp_ctrl #(
  parameter int NUM_BUF       = 3,
  parameter int LOG_NUM_BUF   = 2,
  parameter int NUM_CORE      = 2,
  parameter int NUM_SPLIT     = 4,
  parameter int LOG_NUM_SPLIT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               i_mode,
  input  logic [LOG_NUM_SPLIT-1:0] i_idx_split,
  input  logic                     i_fill_done,
  input  logic                     i_flush,
  input  logic [NUM_CORE-1:0]      i_ntt_done,
  input  logic [NUM_CORE-1:0]      i_madd_done,
  input  logic [NUM_CORE-1:0]      i_wruram_done,
  output logic [LOG_NUM_BUF-1:0]   o_fill_buf,
  output logic [LOG_NUM_BUF-1:0]   o_ntt_buf,
  output logic [LOG_NUM_BUF-1:0]   o_cons_buf,
  output logic                     o_ntt_start,
  output logic                     o_madd_start,
  output logic                     o_wruram_start,
  output logic [1:0]               o_cons_mode,
  output logic [LOG_NUM_SPLIT-1:0] o_cons_idx_split,
  output logic                     o_rotate,
  output logic                     o_busy,
  output logic                     o_err
);

  localparam logic [1:0] MODE_VEC = 2'b01;
  localparam logic [1:0] MODE_MAT = 2'b10;
  localparam logic [LOG_NUM_BUF-1:0] LAST_BUF = LOG_NUM_BUF'(NUM_BUF - 1);
  // Split tags are carried at LOG_NUM_SPLIT bits; the split count itself is informational.
  localparam int unused_num_split = NUM_SPLIT;

  logic [LOG_NUM_BUF-1:0]   ptr;
  logic                     f_done;
  logic [1:0]               f_mode;
  logic [LOG_NUM_SPLIT-1:0] f_split;
  logic                     v_ntt;
  logic [1:0]               n_mode;
  logic [LOG_NUM_SPLIT-1:0] n_split;
  logic                     v_cons;
  logic [1:0]               c_mode;
  logic [LOG_NUM_SPLIT-1:0] c_split;
  logic [NUM_CORE-1:0]      n_done;
  logic [NUM_CORE-1:0]      c_done;

  logic                     cons_mode_ok;
  logic [NUM_CORE-1:0]      cons_done_in;
  logic                     fill_valid;
  logic                     fill_rdy;
  logic                     ntt_rdy;
  logic                     cons_rdy;
  logic                     rot;
  logic                     err_now;
  logic [1:0]               fill_mode_nxt;
  logic [LOG_NUM_SPLIT-1:0] fill_split_nxt;
  logic [LOG_NUM_BUF-1:0]   ptr_nxt;

  function automatic logic [LOG_NUM_BUF-1:0] buf_back(input logic [LOG_NUM_BUF-1:0] p,
                                                      input int k);
    int s;
    s = int'(p) - k;
    if (s < 0) s = s + NUM_BUF;
    return LOG_NUM_BUF'(s);
  endfunction

  // Rotation decision: same-cycle dones are folded in so they close the current epoch
  always_comb begin
    cons_mode_ok   = (c_mode == MODE_VEC) || (c_mode == MODE_MAT);
    cons_done_in   = '0;
    if (c_mode == MODE_MAT) cons_done_in = i_madd_done;
    if (c_mode == MODE_VEC) cons_done_in = i_wruram_done;
    fill_valid     = f_done | i_fill_done;
    fill_rdy       = fill_valid | i_flush;
    ntt_rdy        = !v_ntt | (&(n_done | i_ntt_done));
    cons_rdy       = !v_cons | (&(c_done | cons_done_in)) | !cons_mode_ok;
    // Hold off one cycle after a rotation so no epoch ends in its own start cycle.
    rot            = fill_rdy & ntt_rdy & cons_rdy & !o_rotate;
    err_now        = (i_fill_done & f_done)
                   | ((|i_ntt_done) & !v_ntt)
                   | (((|i_madd_done) | (|i_wruram_done)) & !v_cons)
                   | (v_cons & !cons_mode_ok);
    // A fresh fill in the closing cycle wins over a stale latched tag.
    fill_mode_nxt  = i_fill_done ? i_mode      : f_mode;
    fill_split_nxt = i_fill_done ? i_idx_split : f_split;
    ptr_nxt        = (ptr == LAST_BUF) ? '0 : ptr + LOG_NUM_BUF'(1);
  end

  // Epoch state and registered control pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr            <= '0;
      f_done         <= 1'b0;
      f_mode         <= '0;
      f_split        <= '0;
      v_ntt          <= 1'b0;
      n_mode         <= '0;
      n_split        <= '0;
      v_cons         <= 1'b0;
      c_mode         <= '0;
      c_split        <= '0;
      n_done         <= '0;
      c_done         <= '0;
      o_rotate       <= 1'b0;
      o_ntt_start    <= 1'b0;
      o_madd_start   <= 1'b0;
      o_wruram_start <= 1'b0;
      o_err          <= 1'b0;
    end else begin
      o_rotate       <= rot;
      o_ntt_start    <= rot & fill_valid;
      o_madd_start   <= rot & v_ntt & (n_mode == MODE_MAT);
      o_wruram_start <= rot & v_ntt & (n_mode == MODE_VEC);
      o_err          <= o_err | err_now;
      if (rot) begin
        ptr     <= ptr_nxt;
        v_cons  <= v_ntt;
        c_mode  <= n_mode;
        c_split <= n_split;
        v_ntt   <= fill_valid;
        n_mode  <= fill_mode_nxt;
        n_split <= fill_split_nxt;
        f_done  <= 1'b0;
        f_mode  <= '0;
        f_split <= '0;
        n_done  <= '0;
        c_done  <= '0;
      end else begin
        n_done <= n_done | i_ntt_done;
        c_done <= c_done | cons_done_in;
        if (i_fill_done) begin
          f_done  <= 1'b1;
          f_mode  <= i_mode;
          f_split <= i_idx_split;
        end
      end
    end
  end

  assign o_fill_buf       = ptr;
  assign o_ntt_buf        = buf_back(ptr, 1);
  assign o_cons_buf       = buf_back(ptr, 2);
  assign o_cons_mode      = c_mode;
  assign o_cons_idx_split = c_split;
  assign o_busy           = v_ntt | v_cons;

endmodule
